// File: rtl/fourier_sequencer.sv
// Sequencer for an external transform core: streams N samples into the core,
// waits for the core to finish (with a cycle timeout), then streams the N
// complex results out. Abort cancels a run; err flags a core timeout.
module fourier_sequencer #(
  parameter int N       = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_re,
  output logic [31:0] out_im,
  output logic        out_last,
  output logic [1:0]  core_op,
  output logic [31:0] core_addr,
  output logic [31:0] core_x,
  input  logic [31:0] core_y_re,
  input  logic [31:0] core_y_im,
  input  logic        core_done,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PROC  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, PROC, READ} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          done_nx, err_nx;

  // Core read has zero latency, so results pass straight through.
  assign out_re = core_y_re;
  assign out_im = core_y_im;
  assign busy   = (state != IDLE);

  // State, counters and status flags; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tcnt  <= tcnt_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  // Next-state, counter updates and per-state core/stream outputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    tcnt_nx   = tcnt;
    done_nx   = 1'b0;
    err_nx    = err;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    core_op   = OP_HOLD;
    core_addr = '0;
    core_x    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        core_x    = in_data;
        core_addr = 32'(cnt);
        core_op   = in_valid ? OP_WRITE : OP_HOLD;
        if (in_valid) begin
          if (cnt == CNT_LAST) begin
            state_nx = PROC;
            cnt_nx   = '0;
            tcnt_nx  = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      PROC: begin
        core_op = OP_PROC;
        if (core_done) begin
          state_nx = READ;
          cnt_nx   = '0;
          tcnt_nx  = '0;
        end else if (tcnt == TIME_LAST) begin
          state_nx = IDLE;
          tcnt_nx  = '0;
          err_nx   = 1'b1;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      READ: begin
        core_op   = OP_READ;
        core_addr = 32'(cnt);
        out_valid = 1'b1;
        out_last  = (cnt == CNT_LAST);
        if (out_ready) begin
          if (cnt == CNT_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides any transition, including a same-cycle start.
    if (abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      tcnt_nx  = '0;
      done_nx  = 1'b0;
      err_nx   = err;
    end
  end

endmodule

// File: tb/tb_fourier_sequencer.sv
// Directed bench for fourier_sequencer with a small transform-core stub:
// the stub stores written samples and returns re = x + 100, im = addr * 3.
module tb_fourier_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid, out_ready, core_done;
  logic        in_ready, out_valid, out_last, busy, done, err;
  logic [31:0] in_data, out_re, out_im, core_addr, core_x, core_y_re, core_y_im;
  logic [1:0]  core_op;

  int n_cmp = 0;
  int n_bad = 0;

  fourier_sequencer #(.N(10), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_last(out_last), .core_op(core_op),
    .core_addr(core_addr), .core_x(core_x), .core_y_re(core_y_re),
    .core_y_im(core_y_im), .core_done(core_done), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // core stub
  logic [31:0] mem [0:15];
  logic [31:0] wr_log [$];
  int          proc_seen = 0;
  int          ld_cyc = 0;
  bit          core_en = 1'b1;

  assign core_y_re = mem[core_addr[3:0]] + 32'd100;
  assign core_y_im = core_addr * 32'd3;
  // done is raised in the 5th PROC cycle when the stub is enabled
  assign core_done = core_en && (core_op == 2'b10) && (proc_seen == 4);

  // stub memory, write log, PROC-cycle and LOAD-cycle monitors
  always @(posedge clk) begin
    if (core_op == 2'b01) begin
      mem[core_addr[3:0]] <= core_x;
      wr_log.push_back(core_addr);
    end
    proc_seen <= (core_op == 2'b10) ? proc_seen + 1 : 0;
    if (in_ready) ld_cyc <= ld_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_op",     32'(core_op), 0);
    chk("rst_addr",   core_addr, 0);
    chk("rst_x",      core_x, 0);
    chk("rst_rdy",    32'(in_ready), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_olast",  32'(out_last), 0);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_samples(input bit gaps);
    int base_cyc = ld_cyc;
    int base_wr  = wr_log.size();
    for (int i = 0; i < 10; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        #1;
        chk("gap_op",  32'(core_op), 0);
        chk("gap_rdy", 32'(in_ready), 1);
        step();
      end
      in_valid = 1'b1;
      in_data  = i * 11;
      #1;
      chk("ld_op",   32'(core_op), 1);
      chk("ld_addr", core_addr, i);
      chk("ld_x",    core_x, i * 11);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("ld_cycles", ld_cyc - base_cyc, gaps ? 20 : 10);
    chk("wr_count", wr_log.size() - base_wr, 10);
    for (int k = 0; k < 10 && base_wr + k < wr_log.size(); k++)
      chk("wr_addr", wr_log[base_wr + k], k);
  endtask

  task automatic proc_wait(output int n);
    n = 0;
    while (core_op == 2'b10 && n < 50) begin
      chk("proc_busy", 32'(busy), 1);
      step();
      n++;
    end
  endtask

  task automatic read_out(input bit bp, input int abort_at);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) begin
        #1;
        chk("ab_addr", core_addr, i);
        abort     = 1'b1;
        out_ready = 1'b0;
        step();
        abort = 1'b0;
        #1;
        chk("ab_busy",   32'(busy), 0);
        chk("ab_ovalid", 32'(out_valid), 0);
        chk("ab_op",     32'(core_op), 0);
        chk("ab_done",   32'(done), 0);
        step();
        chk("ab_done2",  32'(done), 0);
        return;
      end
      #1;
      chk("rd_valid", 32'(out_valid), 1);
      chk("rd_op",    32'(core_op), 3);
      chk("rd_addr",  core_addr, i);
      chk("rd_re",    out_re, i * 11 + 100);
      chk("rd_im",    out_im, i * 3);
      chk("rd_last",  32'(out_last), 32'(i == 9));
      chk("rd_done",  32'(done), 0);
      if (bp && i == 4) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("bp_valid", 32'(out_valid), 1);
          chk("bp_addr",  core_addr, 4);
          chk("bp_re",    out_re, 144);
          chk("bp_im",    out_im, 12);
        end
        out_ready = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("end_done",   32'(done), 1);
    chk("end_busy",   32'(busy), 0);
    chk("end_ovalid", 32'(out_valid), 0);
    step();
    chk("end_done2",  32'(done), 0);
  endtask

  task automatic full_run(input bit gaps, input bit bp);
    int n;
    start_run();
    load_samples(gaps);
    proc_wait(n);
    chk("proc_cycles", n, 5);
    read_out(bp, -1);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    step(); step();
    chk_reset_vals();
    reset = 1'b1;
    step();

    // abort beats start in the same cycle
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_prio", 32'(busy), 0);

    // nominal, input gaps, output backpressure
    full_run(1'b0, 1'b0);
    full_run(1'b1, 1'b0);
    full_run(1'b0, 1'b1);

    // timeout: core never finishes
    core_en = 1'b0;
    start_run();
    load_samples(1'b0);
    proc_wait(n);
    chk("to_cycles", n, 8);
    chk("to_err",  32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    step();
    chk("to_err_hold", 32'(err), 1);
    core_en = 1'b1;
    start_run();
    chk("err_clear", 32'(err), 0);
    chk("err_busy",  32'(busy), 1);
    load_samples(1'b0);
    proc_wait(n);
    read_out(1'b0, 3);

    // reset in the middle of PROC, then a clean run
    start_run();
    load_samples(1'b0);
    step();
    chk("mid_proc_op", 32'(core_op), 2);
    reset = 1'b0;
    step();
    chk_reset_vals();
    reset = 1'b1;
    step();
    full_run(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fourier_sequencer.md
FOURIER_SEQUENCER -- requirements
Module: fourier_sequencer

Interface
REQ-001 SHALL have parameter N, default 10, the number of samples per transform.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the maximum number of PROC cycles to wait for core_done.
REQ-003 SHALL have port clk, input, 1, the clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to run one transform.
REQ-006 SHALL have port abort, input, 1, a synchronous cancel of the current run.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32), forming the sample input stream.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_re (output, 32), out_im (output, 32) and out_last (output, 1), forming the result stream.
REQ-009 SHALL have ports core_op (output, 2), core_addr (output, 32) and core_x (output, 32), which drive the transform core.
REQ-010 SHALL have ports core_y_re (input, 32), core_y_im (input, 32) and core_done (input, 1), which return data from the transform core.
REQ-011 SHALL have ports busy (output, 1), done (output, 1) and err (output, 1), giving status.

Function
REQ-012 SHALL use a core_op encoding of 00 idle/hold, 01 write sample, 10 process, 11 read result.
REQ-013 SHALL implement the states IDLE, LOAD, PROC and READ, with a sample counter of width $clog2(N).
REQ-014 SHALL, in IDLE with start=1, go to LOAD in the next cycle with counter=0; start SHALL be ignored in every state other than IDLE.
REQ-015 SHALL, in LOAD, drive in_ready=1, core_x=in_data and core_addr=counter zero-extended to 32 bits.
REQ-016 SHALL, in LOAD, drive core_op=01 only in cycles where in_valid=1 (combinational from in_valid), and core_op=00 otherwise.
REQ-017 SHALL increment the counter on each LOAD handshake; the handshake at counter=N-1 SHALL move the FSM to PROC and clear the counter.
REQ-018 SHALL, in PROC, drive core_op=10 every cycle and count the cycles spent in PROC.
REQ-019 SHALL move from PROC to READ with counter=0 in the cycle after core_done is sampled 1.
REQ-020 SHALL, if core_done is still 0 after TIMEOUT PROC cycles, set err=1 and return to IDLE.
REQ-021 SHALL, in READ, drive core_op=11, core_addr=counter and out_valid=1.
REQ-022 SHALL pass core_y_re to out_re and core_y_im to out_im combinationally, since the core read is zero-latency.
REQ-023 SHALL hold counter, core_addr, out_re and out_im stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive out_last=1 exactly when the state is READ and counter=N-1.
REQ-025 SHALL advance the counter on each READ handshake; the handshake with out_last=1 SHALL return the FSM to IDLE and pulse done=1 for one cycle.
REQ-026 SHALL drive busy=1 in LOAD, PROC and READ.
REQ-027 SHALL clear err on the next accepted start.
REQ-028 SHALL, with abort=1 in any state, enter IDLE in the next cycle: counters cleared, core_op=00, no done pulse, err unchanged.
REQ-029 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-030 SHALL keep in_ready=0 in every state other than LOAD and out_valid=0 in every state other than READ.
REQ-031 SHALL never wrap the counter past N-1.
REQ-032 SHALL drive core_op=00, core_addr=0 and core_x=0 in IDLE.

Reset
REQ-033 SHALL, with reset=0 at a clock edge, force state=IDLE, all counters=0, core_op=00, core_addr=0, core_x=0, in_ready=0, out_valid=0, out_last=0, busy=0, done=0 and err=0.
REQ-034 SHALL give reset priority over abort and start, including when reset is asserted mid-LOAD, mid-PROC or mid-READ.

Verification
REQ-035 SHALL cover a nominal run: with N=10, samples 0..9 sent back-to-back and the core model raising done 5 cycles into PROC, core writes appear at addr 0..9, ten reads go out with out_last on the tenth, and done pulses once.
REQ-036 SHALL cover input gaps: in_valid low on alternate cycles gives core_op=00 in each gap cycle, the addr sequence stays 0..9 with no duplicates, and the run takes 20 LOAD cycles.
REQ-037 SHALL cover output backpressure: out_ready low for 3 cycles at counter=4 holds core_addr=4 and out_re/out_im stable, then streaming resumes.
REQ-038 SHALL cover timeout: with TIMEOUT=8 and core_done never raised, err=1 after 8 PROC cycles, the FSM returns to IDLE, and the next start clears err.
REQ-039 SHALL cover abort: abort during READ at counter=3 gives IDLE, busy=0 and out_valid=0 in the next cycle, with no done pulse.
REQ-040 SHALL cover reset mid-run: reset=0 during PROC gives all outputs at their reset values after one edge, and a new run afterwards completes normally.
